output_conditioner: RTL

Transmit-side counterpart to the input conditioner: turns 1-clk set/clear request pulses into a clean, glitch-free output level with guaranteed minimum dwell time.
Drives off-board lines, LEDs and handshake wires from logic that produces edge pulses, for example a downstream input conditioner's rising/falling outputs.
Rate-limits transitions so that the far end's debouncer, with the same T, never sees a level shorter than T cycles.
A request that arrives during a dwell window is buffered, one deep, and applied when the window closes.

---
 rtl/output_conditioner_pkg.sv | 32 +++
 rtl/output_conditioner_dwell_timer.sv | 33 +++
 rtl/output_conditioner.sv | 100 ++++++++++
 3 files changed

// File: rtl/output_conditioner_pkg.sv
// Shared state encodings, request kinds and helpers for the output conditioner.
// Bit 0 of every state encoding equals the driven output level.
package output_conditioner_pkg;

  typedef enum logic [1:0] {
    OC_STABLE_LOW  = 2'b00,
    OC_HOLD_HIGH   = 2'b01,
    OC_STABLE_HIGH = 2'b11,
    OC_HOLD_LOW    = 2'b10
  } oc_state_e;

  typedef enum logic [1:0] {
    REQ_NONE   = 2'b00,
    REQ_SET    = 2'b01,
    REQ_CLR    = 2'b10,
    REQ_TOGGLE = 2'b11
  } oc_req_e;

  // Same-cycle arbitration: clear beats set beats toggle (safe-low policy).
  function automatic oc_req_e resolve_req(input logic set_i, input logic clr_i,
                                          input logic tog_i);
    if (clr_i)      return REQ_CLR;
    else if (set_i) return REQ_SET;
    else if (tog_i) return REQ_TOGGLE;
    else            return REQ_NONE;
  endfunction

  function automatic int oc_cnt_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/output_conditioner_dwell_timer.sv
// Dwell timer: restart_i zeroes the count; expire_o is high on the T-th cycle
// after a restart and stays high until the next restart.
module output_conditioner_dwell_timer
  import output_conditioner_pkg::*;
#(
  parameter int T = 4
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic restart_i,
  output logic expire_o
);

  localparam int CW = oc_cnt_w(T);
  localparam logic [CW-1:0] LAST = CW'(T - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at the terminal value so expire_o stays meaningful between holds.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)          cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/output_conditioner.sv
// Output conditioner: turns set/clear pulses into a level that dwells >= T cycles,
// buffering one opposing request per dwell window. OUTCOND_TOGGLE_EN adds toggle_pulse.
module output_conditioner
  import output_conditioner_pkg::*;
#(
  parameter int T = 4
) (
  input  logic clk,
  input  logic _reset,
  input  logic set_pulse,
  input  logic clr_pulse,
`ifdef OUTCOND_TOGGLE_EN
  input  logic toggle_pulse,
`endif
  output logic sig_out,
  output logic busy,
  output logic pending,
  output logic done
);

  oc_state_e state_q, state_d;
  oc_req_e   req;
  logic      pending_q, pending_d;
  logic      pend_eff;
  logic      restart;
  logic      expire;
  logic      tog;

`ifdef OUTCOND_TOGGLE_EN
  assign tog = toggle_pulse;
`else
  assign tog = 1'b0;
`endif

  assign req = resolve_req(set_pulse, clr_pulse, tog);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pend_eff  = pending_q;
    restart   = 1'b0;
    case (state_q)
      OC_STABLE_LOW: begin
        if (req == REQ_SET || req == REQ_TOGGLE) begin
          state_d = OC_HOLD_HIGH;
          restart = 1'b1;
        end
      end
      OC_STABLE_HIGH: begin
        if (req == REQ_CLR || req == REQ_TOGGLE) begin
          state_d = OC_HOLD_LOW;
          restart = 1'b1;
        end
      end
      default: begin
        // Pending means "target is the opposite of the current level".
        case (req)
          REQ_SET:    pend_eff = ~state_q[0];
          REQ_CLR:    pend_eff = state_q[0];
          REQ_TOGGLE: pend_eff = ~pending_q;
          default:    pend_eff = pending_q;
        endcase
        if (expire) begin
          pending_d = 1'b0;
          if (pend_eff) begin
            state_d = (state_q == OC_HOLD_HIGH) ? OC_HOLD_LOW : OC_HOLD_HIGH;
            restart = 1'b1;
          end else begin
            state_d = (state_q == OC_HOLD_HIGH) ? OC_STABLE_HIGH : OC_STABLE_LOW;
          end
        end else begin
          pending_d = pend_eff;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q   <= OC_STABLE_LOW;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  output_conditioner_dwell_timer #(.T(T)) u_dwell (
    .clk      (clk),
    .rst_ni   (_reset),
    .restart_i(restart),
    .expire_o (expire)
  );

  assign sig_out = state_q[0];
  assign busy    = state_q[0] ^ state_q[1];
  assign pending = pending_q;
  assign done    = busy & expire;

endmodule
